oled_spi_sink: RTL

Receive-side model of the OLED SPI link: samples the chip-select, SCK, MOSI, D/C and reset lines that the SPI video driver sends to the 96x64 panel, and turns the stream into decoded command bytes and addressed pixel writes. It lives in loopback test cases next to the video driver, feeding a scoreboard or shadow framebuffer, so board tests can check the driver without a physical display. It implements the SSD1331-style column/row window commands and auto-incrementing pixel addressing.

---
 rtl/oled_spi_sink_if.sv | 37 +++
 rtl/oled_spi_sink.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_sink_if.sv
// Bundle of the OLED SPI lines and the decoded command/pixel stream.
// frame_done exists only when OLED_SINK_FRAME_EN is defined.
interface oled_spi_sink_if;
  logic       oled_csn;
  logic       oled_clk;
  logic       oled_mosi;
  logic       oled_dc;
  logic       oled_resn;

  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [5:0] pix_y;
  logic [7:0] pix_color;
`ifdef OLED_SINK_FRAME_EN
  logic       frame_done;
`endif

  // Driver side: owns the SPI lines, observes the decoded stream.
  modport master (
`ifdef OLED_SINK_FRAME_EN
    input  frame_done,
`endif
    output oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    input  cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_color
  );

  // Sink side: samples the SPI lines, produces the decoded stream.
  modport slave (
`ifdef OLED_SINK_FRAME_EN
    output frame_done,
`endif
    input  oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    output cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_color
  );
endinterface

// File: rtl/oled_spi_sink.sv
// Receive-side model of the SSD1331-style OLED SPI link: bytes -> commands/pixel writes.
// Optional frame_done strobe enabled by defining OLED_SINK_FRAME_EN.
module oled_spi_sink #(
  parameter int COLS = 96,
  parameter int ROWS = 64
) (
  input  logic           clk,
  input  logic           rst,
  oled_spi_sink_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COL_S,
    COL_E,
    ROW_S,
    ROW_E
  } state_t;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic [7:0] COLS_L   = 8'(COLS);
  localparam logic [6:0] ROWS_L   = 7'(ROWS);
  // Synchronizer bit order: {resn, dc, mosi, sck, csn}; idle levels on reset.
  localparam logic [4:0] SYNC_RST = 5'b10001;

  // ---------------- synchronizers ----------------
  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;

  // ---------------- edge-detect stage ----------------
  logic sck_prev_q, sck_prev_d;
  logic rise_q, rise_d;
  logic csn_dl_q, csn_dl_d;
  logic mosi_dl_q, mosi_dl_d;
  logic dc_dl_q, dc_dl_d;

  // ---------------- byte assembly stage ----------------
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] byte_q, byte_d;
  logic       bdc_q, bdc_d;

  // ---------------- decoder / output stage ----------------
  state_t     state_q, state_d;
  logic [6:0] col_start_q, col_start_d;
  logic [6:0] col_end_q, col_end_d;
  logic [5:0] row_start_q, row_start_d;
  logic [5:0] row_end_q, row_end_d;
  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       pix_valid_q, pix_valid_d;
  logic [7:0] pix_x_q, pix_x_d;
  logic [5:0] pix_y_q, pix_y_d;
  logic [7:0] pix_color_q, pix_color_d;
`ifdef OLED_SINK_FRAME_EN
  logic       frame_done_q, frame_done_d;
`endif

  logic       resn_ok;
  logic       wrap_x, wrap_y;
  logic [6:0] x_nx;
  logic [5:0] y_nx;

  assign resn_ok = sync2_q[4];

  // Synchronizers, SCK edge detect and serial-to-byte assembly.
  always_comb begin
    sync1_d = {bus.oled_resn, bus.oled_dc, bus.oled_mosi, bus.oled_clk, bus.oled_csn};
    sync2_d = sync1_q;

    sck_prev_d = sync2_q[1];
    rise_d     = sync2_q[1] & ~sck_prev_q & ~sync2_q[0];
    csn_dl_d   = sync2_q[0];
    mosi_dl_d  = sync2_q[2];
    dc_dl_d    = sync2_q[3];

    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    byte_d  = byte_q;
    bdc_d   = bdc_q;

    if (csn_dl_q) begin
      cnt_d = '0;
    end else if (rise_q) begin
      shift_d = {shift_q[5:0], mosi_dl_q};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done_d = 1'b1;
        byte_d = {shift_q, mosi_dl_q};
        bdc_d  = dc_dl_q;
      end
    end

    // Panel reset clears the pipeline but sck_prev keeps tracking SCK so
    // releasing it with SCK high cannot fake a rising edge.
    if (!resn_ok) begin
      rise_d   = 1'b0;
      csn_dl_d = 1'b1;
      shift_d  = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      byte_d   = '0;
      bdc_d    = 1'b0;
    end
  end

  // Command decoder FSM, window registers and pixel pointer.
  always_comb begin
    state_d     = state_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    x_d         = x_q;
    y_d         = y_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
`ifdef OLED_SINK_FRAME_EN
    frame_done_d = 1'b0;
`endif

    // ">=" makes an inverted window collapse to a single column/row at start.
    wrap_x = (x_q >= col_end_q);
    wrap_y = (y_q >= row_end_q);
    x_nx   = wrap_x ? col_start_q : x_q + 7'd1;
    y_nx   = y_q;
    if (wrap_x) y_nx = wrap_y ? row_start_q : y_q + 6'd1;
    if ({1'b0, x_nx} >= COLS_L) x_nx = col_start_q;
    if ({1'b0, y_nx} >= ROWS_L) y_nx = row_start_q;

    if (done_q) begin
      if (bdc_q) begin
        pix_valid_d = 1'b1;
        pix_x_d     = {1'b0, x_q};
        pix_y_d     = y_q;
        pix_color_d = byte_q;
        x_d         = x_nx;
        y_d         = y_nx;
`ifdef OLED_SINK_FRAME_EN
        frame_done_d = wrap_x & wrap_y;
`endif
      end else begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = byte_q;
        unique case (state_q)
          IDLE: begin
            if (byte_q == 8'h15)      state_d = COL_S;
            else if (byte_q == 8'h75) state_d = ROW_S;
          end
          COL_S: begin
            col_start_d = byte_q[6:0];
            state_d     = COL_E;
          end
          COL_E: begin
            col_end_d = byte_q[6:0];
            x_d       = col_start_q;
            y_d       = row_start_q;
            state_d   = IDLE;
          end
          ROW_S: begin
            row_start_d = byte_q[5:0];
            state_d     = ROW_E;
          end
          ROW_E: begin
            row_end_d = byte_q[5:0];
            x_d       = col_start_q;
            y_d       = row_start_q;
            state_d   = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (!resn_ok) begin
      state_d     = IDLE;
      col_start_d = '0;
      col_end_d   = COL_LAST;
      row_start_d = '0;
      row_end_d   = ROW_LAST;
      x_d         = '0;
      y_d         = '0;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = '0;
      pix_valid_d = 1'b0;
      pix_x_d     = '0;
      pix_y_d     = '0;
      pix_color_d = '0;
`ifdef OLED_SINK_FRAME_EN
      frame_done_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      sck_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      csn_dl_q    <= 1'b1;
      mosi_dl_q   <= 1'b0;
      dc_dl_q     <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      byte_q      <= '0;
      bdc_q       <= 1'b0;
      state_q     <= IDLE;
      col_start_q <= '0;
      col_end_q   <= COL_LAST;
      row_start_q <= '0;
      row_end_q   <= ROW_LAST;
      x_q         <= '0;
      y_q         <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
`ifdef OLED_SINK_FRAME_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sck_prev_q  <= sck_prev_d;
      rise_q      <= rise_d;
      csn_dl_q    <= csn_dl_d;
      mosi_dl_q   <= mosi_dl_d;
      dc_dl_q     <= dc_dl_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      byte_q      <= byte_d;
      bdc_q       <= bdc_d;
      state_q     <= state_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
`ifdef OLED_SINK_FRAME_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_byte  = cmd_byte_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_color = pix_color_q;
`ifdef OLED_SINK_FRAME_EN
  assign bus.frame_done = frame_done_q;
`endif

endmodule
